// File: rtl/gf180mcu_ocd_io__brk_seq.sv
// Power-segment break sequencer for the IO ring.
// Brings NSEG supply segments up in order 0..NSEG-1, waiting for power-good and a settle
// interval before releasing each isolation clamp, and takes them down in reverse order.
// Power-good timeouts and brown-outs latch a fault until the ring request is withdrawn.
module gf180mcu_ocd_io__brk_seq #(
  parameter int unsigned NSEG    = 4,
  parameter int unsigned SEGW    = 2,
  parameter int unsigned CNTW    = 8,
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic            CLK,
  input  logic            RN,
  inout  wire             VDD,
  inout  wire             VSS,
  input  logic            EN,
  input  logic [NSEG-1:0] PG,
  output logic [NSEG-1:0] SEG_EN,
  output logic [NSEG-1:0] ISO,
  output logic            READY,
  output logic            FAULT,
  output logic [SEGW-1:0] FSEG
);

  localparam logic [SEGW-1:0] IdxLast     = SEGW'(NSEG - 1);
  localparam logic [CNTW-1:0] SettleLast  = CNTW'(SETTLE - 1);
  localparam logic [CNTW-1:0] TimeoutLast = CNTW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StOff,
    StUp,
    StSettle,
    StOn,
    StDown,
    StFault
  } state_e;

  state_e          state_q, state_d;
  logic [SEGW-1:0] idx_q, idx_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NSEG-1:0] seg_en_q, seg_en_d;
  logic [NSEG-1:0] iso_q, iso_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;
  logic [SEGW-1:0] fseg_q, fseg_d;
  logic [NSEG-1:0] pg_s1_q, pgs_q;

  logic [SEGW-1:0] idx_inc, idx_dec;
  logic [CNTW-1:0] cnt_inc;
  logic [SEGW-1:0] fail_idx;

  // Supply pins carry no logic; fold them into a sink so they are visibly consumed.
  wire unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  assign idx_inc = idx_q + SEGW'(1);
  assign idx_dec = idx_q - SEGW'(1);
  assign cnt_inc = cnt_q + CNTW'(1);

  // Lowest segment whose synchronised power-good is low.
  always_comb begin
    fail_idx = '0;
    for (int i = NSEG - 1; i >= 0; i--) begin
      if (!pgs_q[i]) begin
        fail_idx = SEGW'(i);
      end
    end
  end

  // State register, power-good synchroniser and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q  <= StOff;
      idx_q    <= '0;
      cnt_q    <= '0;
      seg_en_q <= '0;
      iso_q    <= '1;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
      fseg_q   <= '0;
      pg_s1_q  <= '0;
      pgs_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      seg_en_q <= seg_en_d;
      iso_q    <= iso_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
      fseg_q   <= fseg_d;
      pg_s1_q  <= PG;
      pgs_q    <= pg_s1_q;
    end
  end

  // Next-state and next-output logic; a withdrawn request always beats a power-good loss.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    seg_en_d = seg_en_q;
    iso_d    = iso_q;
    ready_d  = ready_q;
    fault_d  = fault_q;
    fseg_d   = fseg_q;

    unique case (state_q)
      StOff: begin
        if (EN) begin
          state_d     = StUp;
          idx_d       = '0;
          cnt_d       = '0;
          seg_en_d[0] = 1'b1;
        end
      end

      StUp: begin
        if (!EN) begin
          // Abort: current segment is still isolated, unwind from here.
          state_d = StDown;
          cnt_d   = '0;
        end else if (pgs_q[idx_q]) begin
          state_d = StSettle;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d  = StFault;
          seg_en_d = '0;
          iso_d    = '1;
          ready_d  = 1'b0;
          fault_d  = 1'b1;
          fseg_d   = idx_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StSettle: begin
        if (!EN) begin
          state_d = StDown;
          cnt_d   = '0;
        end else if (!pgs_q[idx_q]) begin
          state_d  = StFault;
          seg_en_d = '0;
          iso_d    = '1;
          ready_d  = 1'b0;
          fault_d  = 1'b1;
          fseg_d   = idx_q;
        end else if (cnt_q == SettleLast) begin
          iso_d[idx_q] = 1'b0;
          cnt_d        = '0;
          if (idx_q == IdxLast) begin
            state_d = StOn;
            ready_d = 1'b1;
          end else begin
            state_d           = StUp;
            idx_d             = idx_inc;
            seg_en_d[idx_inc] = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StOn: begin
        if (!EN) begin
          state_d        = StDown;
          ready_d        = 1'b0;
          idx_d          = IdxLast;
          cnt_d          = '0;
          iso_d[IdxLast] = 1'b1;
        end else if (pgs_q != '1) begin
          state_d  = StFault;
          seg_en_d = '0;
          iso_d    = '1;
          ready_d  = 1'b0;
          fault_d  = 1'b1;
          fseg_d   = fail_idx;
        end
      end

      StDown: begin
        // Power-good is deliberately ignored while unwinding.
        if (cnt_q == SettleLast) begin
          seg_en_d[idx_q] = 1'b0;
          cnt_d           = '0;
          if (idx_q == '0) begin
            state_d = StOff;
          end else begin
            idx_d          = idx_dec;
            iso_d[idx_dec] = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StFault: begin
        if (!EN) begin
          state_d = StOff;
          fault_d = 1'b0;
          fseg_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = StOff;
      end
    endcase
  end

  // Outputs come straight from their registers.
  always_comb begin
    SEG_EN = seg_en_q;
    ISO    = iso_q;
    READY  = ready_q;
    FAULT  = fault_q;
    FSEG   = fseg_q;
  end

  // A segment may only be de-isolated while it is switched on and the ring is sequencing or up.
  always_ff @(posedge CLK) begin
    if (RN) begin
      for (int i = 0; i < NSEG; i++) begin
        assert (iso_q[i] || (seg_en_q[i] &&
                (ready_q || state_q inside {StUp, StSettle, StDown})));
      end
    end
  end

endmodule

// File: tb/tb_gf180mcu_ocd_io__brk_seq.sv
// Directed bench for the ring break sequencer: table of stimulus/expectation records for
// the nominal ramp, unwind and timeout, plus hand-written brown-out, abort and reset cases.
module tb_gf180mcu_ocd_io__brk_seq;

  logic       clk = 1'b0;
  logic       rn;
  logic       en;
  logic [3:0] pg;
  logic [3:0] seg_en_w;
  logic [3:0] iso_w;
  logic       ready_w;
  logic       fault_w;
  logic [1:0] fseg_w;
  wire        vdd_w;
  wire        vss_w;

  assign vdd_w = 1'b1;
  assign vss_w = 1'b0;

  int total = 0;
  int bad   = 0;
  logic seg3_seen;

  always #5 clk = ~clk;

  gf180mcu_ocd_io__brk_seq #(
    .NSEG   (4),
    .SEGW   (2),
    .CNTW   (8),
    .SETTLE (16),
    .TIMEOUT(200)
  ) dut (
    .CLK   (clk),
    .RN    (rn),
    .VDD   (vdd_w),
    .VSS   (vss_w),
    .EN    (en),
    .PG    (pg),
    .SEG_EN(seg_en_w),
    .ISO   (iso_w),
    .READY (ready_w),
    .FAULT (fault_w),
    .FSEG  (fseg_w)
  );

  typedef struct {
    logic       en;
    logic [3:0] pg;
    int         gap;
    logic [3:0] seg;
    logic [3:0] iso;
    logic       rdy;
    logic       flt;
    logic [1:0] fs;
  } vec_t;

  vec_t tab[$];

  task automatic tick();
    @(posedge clk);
    #1;
    seg3_seen = seg3_seen | seg_en_w[3];
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string nm, input logic [3:0] e_seg, input logic [3:0] e_iso,
                       input logic e_rdy, input logic e_flt, input logic [1:0] e_fs);
    total++;
    if (seg_en_w !== e_seg || iso_w !== e_iso || ready_w !== e_rdy ||
        fault_w !== e_flt || fseg_w !== e_fs) begin
      bad++;
      $display("FAIL %s: got seg_en=%b iso=%b ready=%b fault=%b fseg=%0d, want seg_en=%b iso=%b ready=%b fault=%b fseg=%0d",
               nm, seg_en_w, iso_w, ready_w, fault_w, fseg_w,
               e_seg, e_iso, e_rdy, e_flt, e_fs);
    end
  endtask

  initial begin
    seg3_seen = 1'b0;
    rn = 1'b0;
    en = 1'b0;
    pg = 4'hF;

    // Nominal ramp (edges 0,1,16,17,33,34,51,67,68 after EN sampled).
    tab.push_back('{1'b1, 4'hF,  1, 4'b0001, 4'b1111, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'hF,  1, 4'b0001, 4'b1111, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'hF, 15, 4'b0001, 4'b1111, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'hF,  1, 4'b0011, 4'b1110, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'hF, 16, 4'b0011, 4'b1110, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'hF,  1, 4'b0111, 4'b1100, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'hF, 17, 4'b1111, 4'b1000, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'hF, 16, 4'b1111, 4'b1000, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'hF,  1, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'hF, 10, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0});
    // Nominal unwind (edges 0,15,16,32,48,63,64 after EN drop, then idle).
    tab.push_back('{1'b0, 4'hF,  1, 4'b1111, 4'b1000, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b0, 4'hF, 15, 4'b1111, 4'b1000, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b0, 4'hF,  1, 4'b0111, 4'b1100, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b0, 4'hF, 16, 4'b0011, 4'b1110, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b0, 4'hF, 16, 4'b0001, 4'b1111, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b0, 4'hF, 15, 4'b0001, 4'b1111, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b0, 4'hF,  1, 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b0, 4'hF, 20, 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0});
    // Timeout on segment 1: SEG_EN[1] at edge 17, fault at edge 217.
    tab.push_back('{1'b0, 4'b0001,   3, 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'b0001,   1, 4'b0001, 4'b1111, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'b0001,  17, 4'b0011, 4'b1110, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'b0001, 199, 4'b0011, 4'b1110, 1'b0, 1'b0, 2'd0});
    tab.push_back('{1'b1, 4'b0001,   1, 4'b0000, 4'b1111, 1'b0, 1'b1, 2'd1});
    tab.push_back('{1'b1, 4'b0001,  20, 4'b0000, 4'b1111, 1'b0, 1'b1, 2'd1});
    tab.push_back('{1'b0, 4'b0001,   1, 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0});

    run(3);
    check("reset", 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0);
    rn = 1'b1;
    run(3);
    check("idle_off", 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0);

    for (int i = 0; i < tab.size(); i++) begin
      en = tab[i].en;
      pg = tab[i].pg;
      run(tab[i].gap);
      check($sformatf("vec[%0d]", i), tab[i].seg, tab[i].iso, tab[i].rdy, tab[i].flt,
            tab[i].fs);
    end

    // Brown-out on segment 2 while up: two sync edges, then fault on the third.
    pg = 4'hF;
    run(3);
    en = 1'b1;
    run(69);
    check("bo_on", 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0);
    pg = 4'b1011;
    run(2);
    check("bo_sync", 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0);
    run(1);
    check("bo_fault", 4'b0000, 4'b1111, 1'b0, 1'b1, 2'd2);
    run(10);
    check("bo_hold", 4'b0000, 4'b1111, 1'b0, 1'b1, 2'd2);
    en = 1'b0;
    run(1);
    check("bo_clear", 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0);

    // EN drop and PG loss together: orderly unwind, no fault.
    pg = 4'hF;
    run(3);
    en = 1'b1;
    run(69);
    en = 1'b0;
    pg = 4'b1011;
    run(1);
    check("race_down", 4'b1111, 4'b1000, 1'b0, 1'b0, 2'd0);
    run(64);
    check("race_off", 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0);

    // Abort during SETTLE of segment 2 (EN sampled low at edge 40).
    pg = 4'hF;
    run(3);
    seg3_seen = 1'b0;
    en = 1'b1;
    run(40);
    en = 1'b0;
    run(1);
    check("abort_start", 4'b0111, 4'b1100, 1'b0, 1'b0, 2'd0);
    run(16);
    check("abort_seg2", 4'b0011, 4'b1110, 1'b0, 1'b0, 2'd0);
    run(16);
    check("abort_seg1", 4'b0001, 4'b1111, 1'b0, 1'b0, 2'd0);
    run(15);
    check("abort_seg0", 4'b0001, 4'b1111, 1'b0, 1'b0, 2'd0);
    run(1);
    check("abort_off", 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0);
    total++;
    if (seg3_seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_seg3: got seg_en[3] seen=%b, want 0", seg3_seen);
    end
    en = 1'b1;
    run(1);
    check("abort_restart", 4'b0001, 4'b1111, 1'b0, 1'b0, 2'd0);
    run(17);
    check("abort_restart1", 4'b0011, 4'b1110, 1'b0, 1'b0, 2'd0);

    // Reset while segment 1 is in UP; synchroniser restarts empty, so segment 1 comes at 18.
    en = 1'b0;
    run(70);
    en = 1'b1;
    run(18);
    check("rst_pre", 4'b0011, 4'b1110, 1'b0, 1'b0, 2'd0);
    rn = 1'b0;
    run(1);
    check("rst_mid", 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0);
    rn = 1'b1;
    run(1);
    check("rst_up0", 4'b0001, 4'b1111, 1'b0, 1'b0, 2'd0);
    run(17);
    check("rst_edge17", 4'b0001, 4'b1111, 1'b0, 1'b0, 2'd0);
    run(1);
    check("rst_edge18", 4'b0011, 4'b1110, 1'b0, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_ocd_io__brk_seq.md
Name: gf180mcu_ocd_io__brk_seq

Overview:
- Parametrised power-segment break sequencer for the IO ring.
- Controls NSEG ring supply segments. Each segment sits behind a break cell with an enable switch and an isolation clamp.
- Power-up: enables segments in order 0..NSEG-1. Each segment must show power-good and a settle interval before its isolation is released.
- Power-down: reverses the order. Timeouts and brown-outs go to a latched fault state. One instance sits in the ring control logic next to the break cells.

Parameters:
NSEG, 4, number of ring segments (1..16)
SEGW, 2, index width; must satisfy 2**SEGW >= NSEG
CNTW, 8, width of internal cycle counter
SETTLE, 16, settle cycles per segment (1..2**CNTW-1)
TIMEOUT, 200, max cycles waiting for power-good per segment (1..2**CNTW-1)

Ports:
CLK  input  1  clock
RN  input  1  reset; synchronous and active-low
VDD  inout  1  supply pin, no logical function
VSS  inout  1  ground pin, no logical function
EN  input  1  level request: 1 = ring up, 0 = ring down
PG  input  NSEG  per-segment power-good, asynchronous
SEG_EN  output  NSEG  segment switch enable, 1 = on
ISO  output  NSEG  isolation clamp, 1 = isolated
READY  output  1  all segments up and de-isolated
FAULT  output  1  latched fault flag
FSEG  output  SEGW  index of the segment that faulted

Behaviour:
- All outputs are registered.
- Reset (RN=0 sampled at a CLK edge) sets: SEG_EN=0, ISO=all 1, READY=0, FAULT=0, FSEG=0, idx=0, cnt=0, state OFF, PG synchronisers cleared.
- PG passes through a 2-flop synchroniser per bit, giving pgs. Everything below uses pgs only.
- OFF:
  - EN=1 → UP. At the same edge: idx=0, cnt=0, SEG_EN[0]=1.
- UP:
  - pgs[idx]=1 → SETTLE, cnt=0.
  - Otherwise cnt increments.
  - cnt==TIMEOUT-1 with pgs[idx]=0 → FAULT. FAULT therefore rises exactly TIMEOUT edges after SEG_EN[idx] rose.
- SETTLE:
  - cnt increments each cycle.
  - pgs[idx]=0 at any point → FAULT.
  - At cnt==SETTLE-1: ISO[idx]=0.
    - If idx==NSEG-1 → ON and READY=1 at the same edge.
    - Else idx++, cnt=0, SEG_EN[idx+1]=1, state UP.
  - With PG held high, each segment takes exactly SETTLE+1 edges. READY rises NSEG*(SETTLE+1) edges after EN is first sampled high.
- ON:
  - READY=1.
  - Any pgs bit that is 0 → FAULT, with FSEG = lowest failing index.
  - EN=0 → DOWN. At the same edge: READY=0, idx=NSEG-1, cnt=0, ISO[NSEG-1]=1.
- DOWN:
  - cnt increments. At cnt==SETTLE-1: SEG_EN[idx]=0.
    - If idx==0 → OFF.
    - Else idx--, cnt=0, ISO[idx-1]=1.
  - pgs is ignored in DOWN.
  - EN=1 in DOWN is ignored until OFF is reached; OFF then restarts power-up on the next edge.
- Abort during power-up:
  - EN=0 in UP or SETTLE → DOWN from the current idx (ISO[idx] is already 1, so it stays 1). Segments above idx are untouched.
- FAULT:
  - At the entry edge: SEG_EN=0, ISO=all 1, READY=0, FAULT=1, FSEG=idx (or the lowest failing index from ON).
  - Holds until EN=0 is sampled → OFF. FAULT and FSEG clear at that edge.
  - EN=1 alone never leaves FAULT.
- Simultaneous events:
  - EN=0 and a PG loss in the same cycle: EN=0 wins; go to DOWN, no fault.
  - RN=0 overrides everything, including mid-sequence. There is no orderly power-down on reset.
- Invariant, checked by assertion: ISO[i]=0 implies SEG_EN[i]=1 and READY-or-sequencing.

Test Plan:
1. Nominal up: NSEG=4, SETTLE=16, PG=4'hF; EN 0→1 → SEG_EN bits rise at edges 0,17,34,51 after EN sample. ISO clears bit-by-bit at 17,34,51,68. READY=1 at edge 68.
2. Nominal down: from ON, EN 1→0 → ISO[3] high at edge 0. SEG_EN[3] low at edge 16, SEG_EN[0] low at edge 64, then OFF. READY low at edge 0.
3. Timeout: PG=4'b0001, EN=1 → segment 1 never good. FAULT=1 and FSEG=1 exactly 200 edges after SEG_EN[1] rose; SEG_EN=0, ISO=4'hF. EN=0 → FAULT clears on the next edge.
4. Brown-out in ON: drop PG[2] → FAULT after 2-cycle sync plus 1 edge, FSEG=2, all isolated. EN=1 held keeps FAULT latched.
5. Abort mid-ramp: EN drops while idx=2 in SETTLE → DOWN from segment 2. SEG_EN[3] never asserted. OFF reached after 3*SETTLE edges. A subsequent EN=1 restarts from segment 0.
6. Reset mid-sequence: RN=0 during UP idx=1 → next edge: SEG_EN=0, ISO=4'hF, READY=FAULT=0. RN=1 with EN=1 restarts the sequence at segment 0.
